// File: rtl/fb_pkg.sv
// Shared frame-store geometry: QQVGA defaults and bank depth, also used by the
// capture and VGA fetch blocks.
package fb_pkg;

  localparam int FB_DATA_WIDTH = 12;
  localparam int FB_IMG_W      = 160;
  localparam int FB_IMG_H      = 120;
  localparam int FB_ADDR_WIDTH = 15;

  typedef logic bank_t;

  function automatic int fb_depth(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/frame_buffer_bram.sv
// Simple dual-port block RAM holding both frame banks; address MSB is the bank.
// Synchronous read, output held while re is low.
module frame_buffer_bram #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH:0]   waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH:0]   raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [2**(ADDR_WIDTH+1)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store: capture writes one bank while the display reads
// the other; banks swap only at display frame start with a complete frame pending.
// Optional macro FB_DROP_CNT_EN builds the dropped-frame counter (else drop_cnt=0).
module frame_buffer_pingpong
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int IMG_W      = FB_IMG_W,
  parameter int IMG_H      = FB_IMG_H,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  localparam int DEPTH     = fb_depth(IMG_W, IMG_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic                  wr_sof,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_frame_start,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  disp_valid,
  output logic                  frame_ready,
  output logic                  wr_bank,
  output logic [15:0]           drop_cnt
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_L  = (ADDR_WIDTH+1)'(DEPTH - 1);

  bank_t                 rd_bank;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic                  wr_active;
  logic                  vld_p1;
  logic                  zero_p1;
  logic [DATA_WIDTH-1:0] ram_q_p1;

  logic                  wr_start, wr_cont, wr_last, swap, we;
  bank_t                 bank_sel;
  logic [ADDR_WIDTH:0]   waddr;

  always_comb begin
    swap     = rd_frame_start & frame_ready;
    wr_start = wr_valid & wr_sof;
    wr_cont  = wr_valid & ~wr_sof & wr_active & (wr_ptr < DEPTH_L);
    wr_last  = wr_cont & (wr_ptr == LAST_L);
    // A sof coinciding with a swap belongs to the bank being freed by the swap.
    bank_sel = swap ? ~wr_bank : wr_bank;
    we       = wr_start | wr_cont;
    waddr    = {bank_sel, (wr_start ? '0 : wr_ptr[ADDR_WIDTH-1:0])};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      frame_ready <= 1'b0;
      disp_valid  <= 1'b0;
      wr_ptr      <= '0;
      wr_active   <= 1'b0;
    end else begin
      if (swap) begin
        rd_bank    <= wr_bank;
        wr_bank    <= ~wr_bank;
        disp_valid <= 1'b1;
      end
      if (wr_start) begin
        wr_ptr    <= (ADDR_WIDTH+1)'(1);
        wr_active <= 1'b1;
      end else if (wr_cont) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_last) wr_active <= 1'b0;
      end
      if (swap || wr_start) frame_ready <= 1'b0;
      else if (wr_last)     frame_ready <= 1'b1;
    end
  end

`ifdef FB_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else if (wr_start && frame_ready && !swap && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_cnt = '0;
`endif

  // Read stage p0 -> p1: RAM output register plus the force-to-zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      zero_p1 <= 1'b1;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) zero_p1 <= ({1'b0, rd_addr} >= DEPTH_L) || !disp_valid;
    end
  end

  frame_buffer_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr ({rd_bank, rd_addr}),
    .rdata (ram_q_p1)
  );

  assign rd_data  = zero_p1 ? '0 : ram_q_p1;
  assign rd_valid = vld_p1;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Directed bench for frame_buffer_pingpong with a 4x2 frame (DEPTH=8).
module tb_frame_buffer_pingpong;

  localparam int DW = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_sof = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_frame_start = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, disp_valid, frame_ready, wr_bank;
  logic [15:0]   drop_cnt;

  int vectors = 0;
  int errors  = 0;
  int exp_drop = 0;

  frame_buffer_pingpong #(
    .DATA_WIDTH (DW),
    .IMG_W      (4),
    .IMG_H      (2),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_sof         (wr_sof),
    .wr_data        (wr_data),
    .rd_frame_start (rd_frame_start),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .disp_valid     (disp_valid),
    .frame_ready    (frame_ready),
    .wr_bank        (wr_bank),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Writes n pixels base..base+n-1, sof on the first; optional swap pulse on
  // the first and/or last pixel cycle.
  task automatic write_frame(input int base, input int n, input bit fs_first, input bit fs_last);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_sof = (i == 0);
      wr_data = DW'(base + i);
      rd_frame_start = (fs_first && i == 0) || (fs_last && i == n - 1);
      tick();
    end
    wr_valid = 1'b0;
    wr_sof = 1'b0;
    rd_frame_start = 1'b0;
  endtask

  task automatic swap_pulse();
    rd_frame_start = 1'b1;
    tick();
    rd_frame_start = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int addr, input int expv);
    rd_en = 1'b1;
    rd_addr = AW'(addr);
    tick();
    rd_en = 1'b0;
    chk(tag, 32'(rd_data), 32'(expv));
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_disp_valid", 32'(disp_valid), 0);
    chk("rst_frame_ready", 32'(frame_ready), 0);
    chk("rst_wr_bank", 32'(wr_bank), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    rst = 1'b0;
    tick();

    // read before any frame is displayed
    rd_chk("pre_disp_rd_data", 3, 0);
    chk("pre_disp_rd_valid", 32'(rd_valid), 1);
    chk("pre_disp_disp_valid", 32'(disp_valid), 0);
    tick();
    chk("rd_valid_drop", 32'(rd_valid), 0);

    // first full frame and swap
    write_frame(32'h100, 8, 1'b0, 1'b0);
    chk("f1_frame_ready", 32'(frame_ready), 1);
    chk("f1_wr_bank_pre", 32'(wr_bank), 0);
    swap_pulse();
    chk("f1_frame_ready_post", 32'(frame_ready), 0);
    chk("f1_wr_bank_post", 32'(wr_bank), 1);
    chk("f1_disp_valid", 32'(disp_valid), 1);
    for (int a = 0; a < 8; a++) rd_chk("f1_read", a, 32'h100 + a);
    rd_chk("f1_read_oob", 8, 0);
    chk("f1_oob_valid", 32'(rd_valid), 1);

    // short frame then full frame
    write_frame(32'h500, 5, 1'b0, 1'b0);
    chk("short_frame_ready", 32'(frame_ready), 0);
    write_frame(32'h200, 8, 1'b0, 1'b0);
    chk("f2_frame_ready", 32'(frame_ready), 1);
    chk("f2_no_drop", 32'(drop_cnt), 0);
    rd_chk("f2_pre_swap_read", 2, 32'h102);
    swap_pulse();
    chk("f2_wr_bank", 32'(wr_bank), 0);
    for (int a = 0; a < 8; a++) rd_chk("f2_read", a, 32'h200 + a);

    // two complete frames without a swap: one drop
    write_frame(32'h300, 8, 1'b0, 1'b0);
    write_frame(32'h400, 8, 1'b0, 1'b0);
`ifdef FB_DROP_CNT_EN
    exp_drop = 1;
`endif
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    chk("f4_frame_ready", 32'(frame_ready), 1);
    swap_pulse();
    chk("f4_wr_bank", 32'(wr_bank), 1);
    for (int a = 0; a < 8; a++) rd_chk("f4_read", a, 32'h400 + a);

    // swap request with nothing pending
    swap_pulse();
    chk("noswap_wr_bank", 32'(wr_bank), 1);
    chk("noswap_disp_valid", 32'(disp_valid), 1);
    rd_chk("noswap_read", 5, 32'h405);

    // pend 0x600 in bank 1, then sof together with the swap
    write_frame(32'h600, 8, 1'b0, 1'b0);
    chk("f6_frame_ready", 32'(frame_ready), 1);
    wr_valid = 1'b1; wr_sof = 1'b1; wr_data = 12'h700;
    rd_frame_start = 1'b1; rd_en = 1'b1; rd_addr = 4'd1;
    tick();
    wr_sof = 1'b0; rd_frame_start = 1'b0; rd_en = 1'b0;
    chk("sofswap_old_bank_read", 32'(rd_data), 32'h401);
    chk("sofswap_wr_bank", 32'(wr_bank), 0);
    chk("sofswap_frame_ready", 32'(frame_ready), 0);
    chk("sofswap_no_drop", 32'(drop_cnt), 32'(exp_drop));
    for (int i = 1; i < 7; i++) begin
      wr_data = DW'(32'h700 + i);
      tick();
    end
    // last pixel completes in the same cycle as a swap request: no swap
    wr_data = 12'h707; rd_frame_start = 1'b1;
    tick();
    wr_valid = 1'b0; rd_frame_start = 1'b0;
    chk("late_complete_wr_bank", 32'(wr_bank), 0);
    chk("late_complete_ready", 32'(frame_ready), 1);
    for (int a = 0; a < 8; a++) rd_chk("f6_read", a, 32'h600 + a);
    swap_pulse();
    chk("f7_wr_bank", 32'(wr_bank), 1);
    for (int a = 0; a < 8; a++) rd_chk("f7_read", a, 32'h700 + a);

    // reset in the middle of a frame with a read in flight
    rd_en = 1'b1; rd_addr = 4'd4;
    write_frame(32'h800, 3, 1'b0, 1'b0);
    chk("midrst_pre_valid", 32'(rd_valid), 1);
    chk("midrst_pre_data", 32'(rd_data), 32'h704);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rd_data", 32'(rd_data), 0);
    chk("midrst_rd_valid", 32'(rd_valid), 0);
    chk("midrst_disp_valid", 32'(disp_valid), 0);
    chk("midrst_frame_ready", 32'(frame_ready), 0);
    chk("midrst_wr_bank", 32'(wr_bank), 0);
    chk("midrst_drop_cnt", 32'(drop_cnt), 0);
    rd_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rd_chk("postrst_read", 4, 0);
    // pixels without a sof since reset are discarded
    wr_valid = 1'b1; wr_data = 12'hABC;
    for (int i = 0; i < 8; i++) tick();
    wr_valid = 1'b0;
    chk("nosof_frame_ready", 32'(frame_ready), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_pingpong.md
# frame_buffer_pingpong

Single-clock, double-buffered frame store for the camera-to-VGA path. Holds two banks of IMG_W×IMG_H pixels: the capture side streams pixels into the write bank, and the display side reads the other bank by random address. A bank swap happens only at a display frame boundary and only when a complete frame is pending, so the display never shows a torn image. It sits after the capture/CDC stage and in front of the VGA pixel fetch.

## Interface
- DATA_WIDTH, 12: pixel width (bits).
- IMG_W, 160: frame width (pixels).
- IMG_H, 120: frame height (lines).
- ADDR_WIDTH, 15: per-bank address width; must satisfy 2^ADDR_WIDTH ≥ IMG_W*IMG_H.
- DEPTH, IMG_W*IMG_H: pixels per bank (derived; do not override).
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  pixel present on wr_data this cycle.
- wr_sof  in  1  qualifies wr_valid; this pixel is pixel 0 of a new frame.
- wr_data  in  DATA_WIDTH  pixel value.
- rd_frame_start  in  1  one-cycle pulse at display frame start; swap request.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  pixel index within the displayed bank.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  rd_data is valid (rd_en delayed by one cycle).
- disp_valid  out  1  a complete frame has been swapped in at least once.
- frame_ready  out  1  a complete frame is pending in the write bank.
- wr_bank  out  1  bank currently being written.
- drop_cnt  out  16  dropped-frame counter (see Configuration).

## Operation
- Reset values: wr_bank=0, rd_bank=1, frame_ready=0, disp_valid=0, rd_data=0, rd_valid=0, drop_cnt=0, wr_ptr=0, wr_active=0.
- Write: on wr_valid&wr_sof, write the pixel at address 0, set wr_ptr=1, wr_active=1, and clear frame_ready (the pending frame is being overwritten). On wr_valid&!wr_sof&wr_active&wr_ptr<DEPTH, write at wr_ptr and increment wr_ptr.
- Frame complete: the write at address DEPTH-1 sets frame_ready=1 and wr_active=0. Pixels after completion and before the next sof are discarded. Pixels received while wr_active=0 (no sof since reset) are discarded.
- Short frame: a sof arriving before completion abandons the partial frame; frame_ready stays 0.
- Dropped frame: a sof arriving while frame_ready=1 overwrites an unshown complete frame; drop_cnt increments (saturating at 0xFFFF).
- Swap: rd_frame_start with registered frame_ready=1 gives rd_bank←wr_bank, wr_bank←~wr_bank, frame_ready←0, disp_valid←1. With frame_ready=0 it does nothing; the display repeats the current bank.
- Read: rd_data ← mem[{rd_bank, rd_addr}] when rd_en. Force 0 when rd_addr ≥ DEPTH or disp_valid=0. When rd_en=0, rd_data holds its value.
- Physical address = {bank, addr}; each bank is 2^ADDR_WIDTH deep, and entries DEPTH..2^ADDR_WIDTH-1 are unused.

## Timing
- Read latency: 1 cycle, from rd_en/rd_addr to rd_data/rd_valid.
- The swap takes effect on the cycle after rd_frame_start. A read issued in the same cycle as rd_frame_start uses the old rd_bank.
- A frame completing in the same cycle as rd_frame_start does not swap. The swap waits for the next rd_frame_start.
- wr_sof in the same cycle as a swapping rd_frame_start: the swap wins. The sof pixel goes to the new wr_bank (the former rd_bank), frame_ready ends at 0, and no drop is counted.
- Write-to-read of the same location is impossible by construction (the banks always differ).
- A mid-operation reset returns every register to its reset value immediately. Memory contents are undefined, but no output depends on them until disp_valid=1.

## Configuration
- FB_DROP_CNT_EN defined: the drop_cnt counter is implemented as described.
- FB_DROP_CNT_EN undefined: the counter is not built, and drop_cnt is tied to 0. The port is still present.

## Structure
- Shared package fb_pkg holds the QQVGA defaults (IMG_W, IMG_H, DATA_WIDTH, ADDR_WIDTH) and the DEPTH calculation, shared with the capture and VGA blocks.
- Sub-module frame_buffer_bram: single-clock simple dual-port block RAM. It has (ADDR_WIDTH+1)-bit addresses, a synchronous read and a ram_style="block" hint. The top-level module holds the control logic: pointer, bank select, pending, swap and counter.

## Test plan
Bench parameters: IMG_W=4, IMG_H=2, so DEPTH=8.
- Reset, then rd_en at addr 3: rd_data=0, rd_valid=1 one cycle later, disp_valid=0.
- Write frame 0x100..0x107 (sof on the first pixel), then pulse rd_frame_start: frame_ready=1 goes to 0, wr_bank=1, disp_valid=1. Reading addrs 0..7 returns 0x100..0x107, and rd_addr=8 returns 0.
- Write a 5-pixel frame, then sof plus a full frame 0x200..0x207, then a swap: the display shows 0x200..0x207 and frame_ready stays 0 after the short frame.
- Write two complete frames (0x300.., then 0x400..) with no swap between them: drop_cnt=1, and after a swap the display shows 0x400..0x407. With FB_DROP_CNT_EN undefined, drop_cnt=0.
- rd_frame_start with frame_ready=0: rd_bank is unchanged and reads return the previous frame.
- wr_sof in the same cycle as a swapping rd_frame_start: the new frame lands in the former display bank and the displayed data equals the pending frame. Assert reset mid-frame: all outputs return to their reset values.
